// File: rtl/fsm_response_checker.sv
// Response checker for two-output FSMs: preload expected {x,y} vectors, then
// compare one sample per clock and report pass, mismatch count and first failing index.
module fsm_response_checker #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          x,
  input  logic          y,
  input  logic          ld_valid,
  input  logic [1:0]    ld_data,
  output logic          ld_ready,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [AW:0] Full = DEPTH[AW:0];
  localparam logic [AW:0] One  = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_q, first_d;
  logic [1:0]    mem [DEPTH];

  logic accept;
  logic mem_we;
  logic mismatch;
  logic last;

  assign ld_ready = (state_q == StIdle) && (count_q < Full);
  assign accept   = ld_valid && ld_ready;
  // clear wins over a load issued in the same cycle
  assign mem_we   = accept && !clear;
  assign mismatch = ({x, y} != mem[rd_ptr_q]);
  assign last     = ({1'b0, rd_ptr_q} == (count_q - One));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d = '0;
        end else begin
          if (accept) begin
            count_d = count_q + One;
          end
          // a load on the start edge is part of the run
          if (start && ((count_q != '0) || accept)) begin
            state_d   = StRun;
            rd_ptr_d  = '0;
            err_cnt_d = '0;
            first_d   = '0;
          end
        end
      end
      StRun: begin
        if (mismatch) begin
          if (err_cnt_q != Full) begin
            err_cnt_d = err_cnt_q + One;
          end
          if (err_cnt_q == '0) begin
            first_d = rd_ptr_q;
          end
        end
        if (last) begin
          state_d = StDone;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      StDone: begin
        if (clear) begin
          state_d   = StIdle;
          count_d   = '0;
          err_cnt_d = '0;
          first_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  // Table contents need no reset; count_q defines which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= ld_data;
    end
  end

  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_cnt_q == '0);
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_fsm_response_checker.sv
// Randomised self-checking bench for fsm_response_checker; expected results are
// computed per run from the loaded vector list and the applied samples.
module tb_fsm_response_checker;

  localparam int Depth = 16;

  logic       clk;
  logic       rstn;
  logic       x;
  logic       y;
  logic       ld_valid;
  logic [1:0] ld_data;
  logic       ld_ready;
  logic       start;
  logic       clear;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_idx;

  int n_chk;
  int n_fail;

  logic [1:0] exp_q[$];
  logic [1:0] samp_q[$];

  fsm_response_checker #(.DEPTH(Depth)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .x            (x),
    .y            (y),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .start        (start),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] v);
    @(negedge clk);
    check("ld_ready", int'(ld_ready), int'(exp_q.size() < Depth));
    ld_valid = 1'b1;
    ld_data  = v;
    if (exp_q.size() < Depth) exp_q.push_back(v);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic clear_tbl();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    check("clr_ld_ready", int'(ld_ready), 1);
    check("clr_done", int'(done), 0);
  endtask

  // Runs a compare over exp_q using samp_q as the applied {x,y} sequence.
  task automatic do_run(input bit ld_with, input logic [1:0] ld_v, input bit clr_mid,
                        input string tag);
    int n;
    int errs;
    int first;
    @(negedge clk);
    start = 1'b1;
    if (ld_with) begin
      ld_valid = 1'b1;
      ld_data  = ld_v;
      if (exp_q.size() < Depth) exp_q.push_back(ld_v);
    end
    @(negedge clk);
    start    = 1'b0;
    ld_valid = 1'b0;
    n        = exp_q.size();
    errs     = 0;
    first    = 0;
    for (int i = 0; i < n; i++) begin
      if (samp_q[i] != exp_q[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    if (errs > Depth) errs = Depth;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, int'(busy), 1);
      {x, y} = samp_q[i];
      clear  = clr_mid && (i == 1);
      @(negedge clk);
      clear = 1'b0;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_pass"}, int'(pass), int'(errs == 0));
    check({tag, "_err_cnt"}, int'(err_cnt), errs);
    check({tag, "_first"}, int'(first_err_idx), first);
  endtask

  initial begin
    logic [1:0] v;
    n_chk    = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    x        = 1'b0;
    y        = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 2'b00;
    start    = 1'b0;
    clear    = 1'b0;

    // reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_first", int'(first_err_idx), 0);
    check("rst_ld_ready", int'(ld_ready), 1);

    // all-match run
    for (int i = 0; i < 4; i++) load(2'(i));
    samp_q = '{2'b00, 2'b01, 2'b10, 2'b11};
    do_run(1'b0, 2'b00, 1'b0, "match");
    clear_tbl();

    // two mismatches, clear during RUN ignored
    for (int i = 0; i < 4; i++) load(2'(i));
    samp_q = '{2'b00, 2'b11, 2'b10, 2'b00};
    do_run(1'b0, 2'b00, 1'b1, "mism");
    // start and load in DONE are ignored
    @(negedge clk);
    start    = 1'b1;
    ld_valid = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ld_valid = 1'b0;
    check("done_hold", int'(done), 1);
    check("done_err_hold", int'(err_cnt), 2);
    clear_tbl();

    // full table: 17 loads, 17th dropped; every sample wrong
    for (int i = 0; i < Depth + 1; i++) load(2'($urandom_range(0, 3)));
    check("full_ld_ready", int'(ld_ready), 0);
    samp_q.delete();
    foreach (exp_q[i]) samp_q.push_back(~exp_q[i]);
    do_run(1'b0, 2'b00, 1'b0, "full");
    clear_tbl();

    // start with empty table is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty_start_busy", int'(busy), 0);
    check("empty_start_ready", int'(ld_ready), 1);

    // load + start in the same cycle: run covers that vector
    load(2'b10);
    load(2'b01);
    samp_q = '{2'b10, 2'b01, 2'b11};
    do_run(1'b1, 2'b11, 1'b0, "ldstart");
    clear_tbl();

    // clear + start in IDLE: table emptied, no run
    load(2'b01);
    load(2'b10);
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    exp_q.delete();
    check("clrstart_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clrstart_emptied", int'(busy), 0);

    // reset at the 3rd compare edge of an 8-vector run
    for (int i = 0; i < 8; i++) load(2'(i));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    {x, y} = exp_q[0];
    @(negedge clk);
    {x, y} = 2'(~exp_q[1]);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_ld_ready", int'(ld_ready), 1);
    load(2'b11);
    load(2'b00);
    samp_q = '{2'b11, 2'b00};
    do_run(1'b0, 2'b00, 1'b0, "postrst");
    clear_tbl();

    // randomised runs
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, Depth);
      samp_q.delete();
      for (int i = 0; i < n; i++) begin
        v = 2'($urandom_range(0, 3));
        load(v);
        samp_q.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : v);
      end
      do_run(1'b0, 2'b00, 1'b0, "rand");
      clear_tbl();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_response_checker.md
# fsm_response_checker

Synthesizable response checker for the two-output FSM blocks (`x`, `y`) in this chapter. It is the receiving end of the stimulus path. A driver applies `i`/`j` to the FSM, and this block samples the FSM's `{x,y}` outputs once per clock. Each sample is compared against a preloaded table of expected values. The block reports pass/fail, the mismatch count and the first failing index, so a bench or on-chip harness can grade a run without `$monitor` inspection.

## Interface
- `DEPTH`, 16: number of expected-vector entries; must be a power of two, at least 2.
- `AW`, `$clog2(DEPTH)`: table index width (derived, do not override).
- `clk` in 1: single clock; all logic rising-edge.
- `rstn` in 1: reset is synchronous and active-low.
- `x` in 1: FSM output x, sampled at `clk` rising edge.
- `y` in 1: FSM output y, sampled at `clk` rising edge.
- `ld_valid` in 1: expected-vector write strobe.
- `ld_data` in 2: expected `{x,y}`; bit 1 = x, bit 0 = y.
- `ld_ready` out 1: table can accept a vector.
- `start` in 1: begin a compare run (1-cycle pulse or level).
- `clear` in 1: leave DONE, empty the table.
- `busy` out 1: run in progress.
- `done` out 1: run complete (level until `clear`).
- `pass` out 1: valid when `done`; 1 iff zero mismatches.
- `err_cnt` out AW+1: mismatch count, saturates at DEPTH.
- `first_err_idx` out AW: index of first mismatch; 0 if none.

## Operation
- State machine has three states.
  - IDLE: loading allowed.
  - RUN: comparing.
  - DONE: results held.
- Storage:
  - Table is `mem[DEPTH]` of 2 bits.
  - `count` (AW+1 bits) holds the number of loaded entries.
  - `rd_ptr` (AW bits) is the compare index.
- `ld_ready` = (state==IDLE) && (count<DEPTH).
  - Combinational from registered state and `count` only.
  - Not dependent on `start`.
- Load:
  - A vector is accepted when `ld_valid && ld_ready`.
  - On acceptance, `mem[count] <= ld_data` and `count++`.
  - `ld_valid` while `ld_ready==0` is ignored; no write, no count change.
- Start:
  - In IDLE, `start && count!=0` moves to RUN.
  - On the same edge, `rd_ptr<=0`, `err_cnt<=0`, `first_err_idx<=0`.
  - `start` with `count==0` is ignored; the block stays in IDLE.
  - `start` outside IDLE is ignored.
- Simultaneous load and start in IDLE:
  - The load is accepted and included, so the run length is `count+1`.
- RUN, every cycle:
  - Compare `{x,y}` with `mem[rd_ptr]`.
  - On mismatch, `err_cnt` increments, saturating at DEPTH.
  - If this is the first mismatch (`err_cnt==0` before the update), `first_err_idx<=rd_ptr`.
  - When `rd_ptr==count-1`, go to DONE; otherwise `rd_ptr++`.
  - `rd_ptr` never wraps.
- DONE:
  - `pass = (err_cnt==0)`.
  - Results are held until `clear`.
  - `start` and `ld_valid` are ignored.
  - `clear` goes to IDLE, with `count<=0`, `err_cnt<=0`, `first_err_idx<=0`.
- `clear` in IDLE empties the table (`count<=0`).
  - `clear` in RUN is ignored.
  - `clear` has priority over `start` and over a load in the same cycle.
- Outputs:
  - `busy` = (state==RUN).
  - `done` = (state==DONE).
  - `pass` = done && err_cnt==0.

## Timing
- Reset (`rstn==0` at an edge) sets:
  - state=IDLE, count=0, rd_ptr=0.
  - err_cnt=0, first_err_idx=0.
- Resulting outputs after reset:
  - busy=0, done=0, pass=0, ld_ready=1.
- Reset mid-RUN or in DONE aborts the run with the same values. Table contents are don't-care.
- `start` sampled at edge k puts the block in RUN after edge k.
- Samples of `{x,y}` are taken at edges k+1 … k+N, where N = run length.
- Sample n (0-based) is the value present just before edge k+1+n.
- `done` rises after edge k+N; latency from start to done is N cycles.
- `err_cnt` and `first_err_idx` update on the same edge as the compare that caused them.
- Stimulus alignment: the driver must change `i`/`j` no later than 1 cycle after the start edge for sample 0 to reflect the first stimulus response.
- Load throughput is one vector per cycle. A full table (count==DEPTH) drops `ld_ready` on the edge after the DEPTH-th accept.

## Test plan
- Reset state:
  - Stimulus: hold `rstn=0` for 2 edges, then release.
  - Required: busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, ld_ready=1.
- All-match run:
  - Stimulus: load 00,01,10,11; start; drive `{x,y}` = 00,01,10,11 on the next 4 edges.
  - Required: done exactly 4 cycles after start; pass=1; err_cnt=0.
- Mismatches:
  - Stimulus: load 00,01,10,11; start; drive 00,11,10,00.
  - Required: done; pass=0; err_cnt=2; first_err_idx=1.
- Full table and overflow:
  - Stimulus: load 17 vectors with DEPTH=16.
  - Required: ld_ready=0 after the 16th; the 17th is not written; count=16.
  - Stimulus: a 16-cycle run with every sample wrong.
  - Required: err_cnt=16 (saturated value); first_err_idx=0.
- Corner commands:
  - `start` with empty table: stays IDLE, busy=0.
  - `ld_valid`+`start` in the same cycle: the run covers that vector too.
  - `clear` during RUN: ignored.
  - `clear`+`start` in IDLE: table emptied, no run.
- Reset mid-run:
  - Stimulus: load 8 vectors; start; assert `rstn=0` at the 3rd compare edge.
  - Required: IDLE, err_cnt=0, done=0, ld_ready=1 on the next edge.
  - Stimulus: a new 2-vector load and run.
  - Required: completes with pass=1.
